wb_arbiter: RTL and testbench

Write-back arbiter sitting in front of the register file's single write port. Merges single-cycle ALU results, which are never stalled, with multi-cycle results from the load/mul-div unit, which use a valid/ready handshake. Slow results are buffered in a small FIFO and drained into the write port in cycles when the ALU does not write. Pending-write lookups for two read addresses let decode stall on slow-result RAW hazards.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_fifo.sv | 65 ++++++
 rtl/wb_arbiter.sv | 98 +++++++++
 tb/tb_wb_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter slice.
// Entry widths follow WB_ADDR_W/WB_DATA_W; wb_arbiter's width parameters default to them.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam logic [WB_ADDR_W-1:0] WB_ZERO_REG = '0;

  typedef struct packed {
    logic                 live;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Slow-result FIFO: storage, wrapping pointers and occupancy count, with an
// address-match kill port and parallel live/addr views for hazard lookup.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = WB_ADDR_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wb_entry_t                    push_entry,
  input  logic                         pop,
  input  logic                         kill_en,
  input  logic [ADDR_W-1:0]            kill_addr,
  output wb_entry_t                    head,
  output logic [CNT_W-1:0]             count,
  output logic [DEPTH-1:0]             live_vec,
  output logic [DEPTH-1:0][ADDR_W-1:0] addr_vec
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_killed;

  // A same-cycle ALU write to the same register is younger, so the incoming entry is born dead.
  assign push_killed = kill_en && (push_entry.addr == kill_addr);

  // Popped slots drop their live bit, so live_vec only ever flags occupied entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i].live <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill_en && mem[i].addr == kill_addr) mem[i].live <= 1'b0;
      if (pop) begin
        mem[rd_ptr].live <= 1'b0;
        rd_ptr           <= rd_ptr + 1'b1;
      end
      if (push) begin
        mem[wr_ptr]      <= push_entry;
        mem[wr_ptr].live <= push_entry.live && !push_killed;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      live_vec[i] = mem[i].live;
      addr_vec[i] = mem[i].addr;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: ALU results win, slow results queue in wb_fifo.
// Define WB_BYPASS_EN to let a slow result skip the empty FIFO on an idle port.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_we,
  input  logic [ADDR_W-1:0] alu_waddr,
  input  logic [DATA_W-1:0] alu_wdata,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] s_waddr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] q1addr,
  input  logic [ADDR_W-1:0] q2addr,
  output logic              q1_pend,
  output logic              q2_pend
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t                    push_entry;
  wb_entry_t                    head;
  logic [CNT_W-1:0]             count;
  logic [DEPTH-1:0]             live_vec;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_vec;
  logic                         empty, push, pop, kill_en, bypass;

  assign empty   = (count == '0);
  assign s_ready = !rst && (count < CNT_W'(DEPTH));
  assign kill_en = !rst && alu_we && (alu_waddr != WB_ZERO_REG);
  assign pop     = !rst && !alu_we && !empty;

`ifdef WB_BYPASS_EN
  assign bypass = !rst && !alu_we && empty && s_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push       = s_valid && s_ready && !bypass;
  assign push_entry = '{live: (s_waddr != WB_ZERO_REG), addr: s_waddr, data: s_wdata};

  wb_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (kill_en),
    .kill_addr  (alu_waddr),
    .head       (head),
    .count      (count),
    .live_vec   (live_vec),
    .addr_vec   (addr_vec)
  );

  // An ALU write to r0 still owns the port, so the FIFO holds off that cycle.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (!rst) begin
      if (alu_we) begin
        we    = (alu_waddr != WB_ZERO_REG);
        waddr = alu_waddr;
        wdata = alu_wdata;
      end else if (pop) begin
        we    = head.live;
        waddr = head.addr;
        wdata = head.data;
      end else if (bypass) begin
        we    = (s_waddr != WB_ZERO_REG);
        waddr = s_waddr;
        wdata = s_wdata;
      end
    end
  end

  always_comb begin
    q1_pend = 1'b0;
    q2_pend = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_vec[i] && addr_vec[i] == q1addr) q1_pend = 1'b1;
      if (live_vec[i] && addr_vec[i] == q2addr) q2_pend = 1'b1;
    end
    if (rst || q1addr == WB_ZERO_REG) q1_pend = 1'b0;
    if (rst || q2addr == WB_ZERO_REG) q2_pend = 1'b0;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter against a queue-based reference model.
// Honours WB_BYPASS_EN in the model when the design is built with it.
module tb_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        alu_we;
  logic [4:0]  alu_waddr;
  logic [31:0] alu_wdata;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  s_waddr;
  logic [31:0] s_wdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  q1addr;
  logic [4:0]  q2addr;
  logic        q1_pend;
  logic        q2_pend;

  typedef struct {
    bit          live;
    logic [4:0]  addr;
    logic [31:0] data;
  } model_entry_t;

  model_entry_t mq[$];
  logic [31:0]  rf_model [32];
  logic [31:0]  rf_dut   [32];
  int           vectors;
  int           miscompares;

  wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_we    (alu_we),
    .alu_waddr (alu_waddr),
    .alu_wdata (alu_wdata),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_waddr   (s_waddr),
    .s_wdata   (s_wdata),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .q1addr    (q1addr),
    .q2addr    (q2addr),
    .q1_pend   (q1_pend),
    .q2_pend   (q2_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic bit model_pending(input logic [4:0] a);
    bit hit = 0;
    foreach (mq[i]) if (mq[i].live && mq[i].addr == a && a != 5'd0) hit = 1;
    return hit;
  endfunction

  // One clock: predict from the model, check at negedge, advance the model after posedge.
  task automatic run_cycle();
    logic        e_we, e_rdy, e_p1, e_p2, byp;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    model_entry_t dummy;
    e_rdy  = !rst && (mq.size() < DEPTH);
    byp    = 0;
    e_we   = 0;
    e_addr = '0;
    e_data = '0;
    if (!rst) begin
      if (alu_we) begin
        e_we = (alu_waddr != 0); e_addr = alu_waddr; e_data = alu_wdata;
      end else if (mq.size() > 0) begin
        e_we = mq[0].live; e_addr = mq[0].addr; e_data = mq[0].data;
      end
`ifdef WB_BYPASS_EN
      else if (s_valid) begin
        byp = 1; e_we = (s_waddr != 0); e_addr = s_waddr; e_data = s_wdata;
      end
`endif
    end
    e_p1 = !rst && model_pending(q1addr);
    e_p2 = !rst && model_pending(q2addr);
    @(negedge clk);
    check_output("s_ready", {31'd0, s_ready}, {31'd0, e_rdy});
    check_output("we", {31'd0, we}, {31'd0, e_we});
    check_output("q1_pend", {31'd0, q1_pend}, {31'd0, e_p1});
    check_output("q2_pend", {31'd0, q2_pend}, {31'd0, e_p2});
    if (rst || e_we) begin
      check_output("waddr", {27'd0, waddr}, {27'd0, e_addr});
      check_output("wdata", wdata, e_data);
    end
    if (we) rf_dut[waddr] = wdata;
    if (e_we) rf_model[e_addr] = e_data;
    @(posedge clk);
    if (rst) mq.delete();
    else begin
      if (!alu_we && mq.size() > 0) dummy = mq.pop_front();
      if (alu_we && alu_waddr != 0)
        foreach (mq[i]) if (mq[i].addr == alu_waddr) mq[i].live = 0;
      if (s_valid && e_rdy && !byp)
        mq.push_back('{live: (s_waddr != 0) && !(alu_we && alu_waddr == s_waddr),
                       addr: s_waddr, data: s_wdata});
    end
    #1;
  endtask

  task automatic apply_stimulus(input logic r, input logic awe, input logic [4:0] aa, input logic [31:0] ad,
                                input logic sv, input logic [4:0] sa, input logic [31:0] sd,
                                input logic [4:0] qa1, input logic [4:0] qa2);
    rst = r; alu_we = awe; alu_waddr = aa; alu_wdata = ad;
    s_valid = sv; s_waddr = sa; s_wdata = sd; q1addr = qa1; q2addr = qa2;
    run_cycle();
  endtask

  task automatic idle(input logic [4:0] qa1, input logic [4:0] qa2);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, qa1, qa2);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < 32; i++) begin
      rf_model[i] = '0;
      rf_dut[i]   = '0;
    end
    $display("[TB] wb_arbiter bench start");

    // Reset held with both write sources active.
    apply_stimulus(1, 1, 5'd4, 32'hAAAA, 1, 5'd6, 32'hBBBB, 5'd6, 5'd4);
    apply_stimulus(1, 1, 5'd4, 32'hAAAA, 1, 5'd6, 32'hBBBB, 5'd6, 5'd4);
    idle(0, 0);

    // Slow-only push, then the drain cycle with a hazard query on r5.
    apply_stimulus(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 0);
    idle(5'd5, 0);
    idle(5'd5, 0);

    // ALU holds the port for three cycles while r3 waits.
    apply_stimulus(0, 1, 5'd1, 32'h101, 1, 5'd3, 32'h303, 5'd3, 0);
    apply_stimulus(0, 1, 5'd2, 32'h102, 0, 0, 0, 5'd3, 0);
    apply_stimulus(0, 1, 5'd4, 32'h104, 0, 0, 0, 5'd3, 0);
    idle(5'd3, 0);
    idle(5'd3, 0);

    // Fill the FIFO behind the ALU; the fifth offer must be refused.
    for (int i = 0; i < 5; i++)
      apply_stimulus(0, 1, 5'd20, 32'h200 + i, 1, 5'(10 + i), 32'h1000 + i, 5'(10 + i), 5'd14);
    apply_stimulus(0, 0, 0, 0, 1, 5'd14, 32'h1004, 5'd14, 5'd11);
    for (int i = 0; i < 5; i++) idle(5'd14, 5'd12);

    // WAW kill: r7=0x11 queued, ALU overwrites r7=0x22, drain is a no-op.
    apply_stimulus(0, 1, 5'd1, 32'h1, 1, 5'd7, 32'h11, 5'd7, 0);
    apply_stimulus(0, 1, 5'd7, 32'h22, 0, 0, 0, 5'd7, 0);
    idle(5'd7, 0);
    idle(5'd7, 0);
    check_output("r7_final", rf_dut[7], 32'h22);

    // Same-cycle kill of an incoming slow result.
    apply_stimulus(0, 1, 5'd8, 32'h88, 1, 5'd8, 32'h77, 5'd8, 0);
    idle(5'd8, 0);

    // Zero register: accepted, drains silently, never pending.
    apply_stimulus(0, 1, 5'd1, 32'h2, 1, 5'd0, 32'hF00D, 0, 0);
    idle(0, 0);

    // ALU write to r0 still blocks the drain.
    apply_stimulus(0, 1, 5'd1, 32'h3, 1, 5'd2, 32'h222, 5'd2, 0);
    apply_stimulus(0, 1, 5'd0, 32'h999, 0, 0, 0, 5'd2, 0);
    idle(5'd2, 0);

    // Bypass candidates: idle port, then ALU contention.
    apply_stimulus(0, 0, 0, 0, 1, 5'd9, 32'h1234, 5'd9, 0);
    apply_stimulus(0, 1, 5'd1, 32'h4, 1, 5'd9, 32'h5678, 5'd9, 0);
    idle(5'd9, 0);
    idle(5'd9, 0);

    // Reset mid-operation discards queued writes.
    apply_stimulus(0, 1, 5'd1, 32'h5, 1, 5'd12, 32'hC0, 5'd12, 0);
    apply_stimulus(0, 1, 5'd1, 32'h6, 1, 5'd13, 32'hD0, 5'd12, 5'd13);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 5'd12, 5'd13);
    idle(5'd12, 5'd13);

    // Randomized traffic over a narrow address range to provoke collisions.
    for (int n = 0; n < 400; n++)
      apply_stimulus(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                     $urandom, $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    for (int i = 0; i < 6; i++) idle(0, 0);

    for (int i = 1; i < 32; i++) check_output($sformatf("rf[%0d]", i), rf_dut[i], rf_model[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
